// File: rtl/inst_encoder_loader.sv
// Octa16 program loader: packs decoded field tuples into 16-bit instruction words
// and streams them into imem, halting on the first tuple that has no legal encoding.
module inst_encoder_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_opcode,
  input  logic [2:0]        in_func,
  input  logic [2:0]        in_rd,
  input  logic [2:0]        in_rs1,
  input  logic [2:0]        in_rs2,
  input  logic [7:0]        in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

  localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   C_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   r_accepted;
  logic [ADDR_W:0]   r_words;
  logic [ADDR_W-1:0] r_next_addr;
  logic [ADDR_W-1:0] r_waddr;
  logic [ADDR_W-1:0] r_err_addr;
  logic [15:0]       r_wdata;
  logic              r_we;
  logic              w_in_ready;
  logic              w_acc;
  logic              w_wr_done;
  logic              w_start_ok;
  logic              w_legal;
  logic [15:0]       w_word;
  logic [ADDR_W:0]   w_words_inc;

  // Returns {legal, word}; the word is only meaningful when legal is set.
  function automatic logic [16:0] encode(input logic [2:0] op, input logic [2:0] f,
                                         input logic [2:0] rd, input logic [2:0] rs1,
                                         input logic [2:0] rs2, input logic [7:0] imm);
    logic        lg;
    logic [15:0] w;
    logic        imm_small;
    lg        = 1'b0;
    w         = 16'h0000;
    imm_small = (&imm[7:3]) || !(|imm[7:3]);
    case (op)
      3'b000: begin w = {1'b0, rs2, rs1, rd, f, op}; lg = 1'b1; end
      3'b001: begin w = {imm[3:0], rs1, rd, f, op}; lg = imm_small; end
      3'b010, 3'b011: begin
        w  = {imm[7], imm[5:3], rs1, rd, imm[2:0], op};
        lg = (imm[7] == imm[6]);
      end
      3'b100: begin w = {imm[7], rs2, rs1, imm[2:0], f, op}; lg = imm_small; end
      3'b101: begin
        if (f == 3'b000) begin
          w = {imm[6:0], rd, 3'b000, op}; lg = !imm[7];
        end else if (f == 3'b100) begin
          w = {imm[7:4], rs1, rd, 3'b100, op}; lg = (imm[3:0] == 4'h0);
        end
      end
      3'b110: begin
        if (f == 3'b001) begin
          w = {imm[6:0], rd, 3'b001, op}; lg = (imm[7] == imm[6]);
        end else if (f == 3'b000) begin
          w = {imm[7:4], rs1, rd, 3'b000, op}; lg = (imm[3:0] == 4'h0);
        end
      end
      default: lg = 1'b0;
    endcase
    return {lg, w};
  endfunction

  assign {w_legal, w_word} = encode(in_opcode, in_func, in_rd, in_rs1, in_rs2, in_imm);

  // Stage may accept a new tuple in the same cycle it hands its word to imem.
  assign w_in_ready  = (r_state == S_RUN) && (r_accepted < r_count) && (!r_we || mem_ready);
  assign w_acc       = in_valid && w_in_ready;
  assign w_wr_done   = r_we && mem_ready;
  assign w_start_ok  = start && (r_state != S_RUN);
  assign w_words_inc = r_words + C_ONE;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    case (r_state)
      S_RUN: begin
        busy = 1'b1;
        if (w_acc && !w_legal)                          w_next = S_ERR;
        else if (w_wr_done && (w_words_inc == r_count)) w_next = S_DONE;
      end
      S_DONE:  done = 1'b1;
      S_ERR:   err  = 1'b1;
      default: ;
    endcase
    if (w_start_ok) w_next = (count == '0) ? S_DONE : S_RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_accepted  <= '0;
      r_words     <= '0;
      r_next_addr <= '0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_err_addr  <= '0;
    end else if (w_start_ok) begin
      r_count     <= count;
      r_accepted  <= '0;
      r_words     <= '0;
      r_next_addr <= base_addr;
      r_we        <= 1'b0;
      r_err_addr  <= '0;
    end else begin
      if (w_wr_done) begin
        r_words <= w_words_inc;
        r_we    <= 1'b0;
      end
      if (w_acc) begin
        r_accepted  <= r_accepted + C_ONE;
        r_next_addr <= r_next_addr + A_ONE;
        if (w_legal) begin
          r_we    <= 1'b1;
          r_waddr <= r_next_addr;
          r_wdata <= w_word;
        end else begin
          r_err_addr <= r_next_addr;
        end
      end
    end
  end

  assign in_ready      = w_in_ready;
  assign mem_we        = r_we;
  assign mem_addr      = r_waddr;
  assign mem_wdata     = r_wdata;
  assign err_addr      = r_err_addr;
  assign words_written = r_words;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Self-checking bench for inst_encoder_loader: directed jobs plus randomized jobs
// scored against an arithmetic model of the Octa16 encoding rules.
module tb_inst_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  count;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_opcode, in_func, in_rd, in_rs1, in_rs2;
  logic [7:0]  in_imm;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ready;
  logic        busy, done, err;
  logic [7:0]  err_addr;
  logic [8:0]  words_written;

  int n_cmp = 0;
  int n_err = 0;

  int t_op[16], t_f[16], t_rd[16], t_rs1[16], t_rs2[16], t_imm[16];
  int exp_addr_q[$];
  int exp_data_q[$];
  int g_cyc, g_nwr;
  int g_wr_cyc[16];

  inst_encoder_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_func(in_func),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr), .words_written(words_written)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference encoding: -1 for an unencodable tuple, else the 16-bit word.
  function automatic int ref_enc(input int op, input int f, input int rd, input int rs1,
                                 input int rs2, input int imm);
    int simm;
    simm = (imm >= 128) ? imm - 256 : imm;
    case (op)
      0: return 8*f + 64*rd + 512*rs1 + 4096*rs2;
      1: begin
        if (simm < -8 || simm > 7) return -1;
        return 1 + 8*f + 64*rd + 512*rs1 + 4096*(imm % 16);
      end
      2, 3: begin
        if (simm < -64 || simm > 63) return -1;
        return op + 8*(imm % 8) + 64*rd + 512*rs1 + 4096*((imm / 8) % 8) + 32768*(imm / 128);
      end
      4: begin
        if (simm < -8 || simm > 7) return -1;
        return 4 + 8*f + 64*(imm % 8) + 512*rs1 + 4096*rs2 + 32768*(imm / 128);
      end
      5: begin
        if (f == 0) return (imm >= 128) ? -1 : 5 + 64*rd + 512*(imm % 128);
        if (f == 4) return (imm % 16 != 0) ? -1 : 5 + 32 + 64*rd + 512*rs1 + 4096*(imm / 16);
        return -1;
      end
      6: begin
        if (f == 1) return (simm < -64 || simm > 63) ? -1 : 6 + 8 + 64*rd + 512*(imm % 128);
        if (f == 0) return (imm % 16 != 0) ? -1 : 6 + 64*rd + 512*rs1 + 4096*(imm / 16);
        return -1;
      end
      default: return -1;
    endcase
  endfunction

  task automatic set_t(input int i, input int op, input int f, input int rd, input int rs1,
                       input int rs2, input int imm);
    t_op[i] = op; t_f[i] = f; t_rd[i] = rd; t_rs1[i] = rs1; t_rs2[i] = rs2; t_imm[i] = imm;
  endtask

  task automatic gen_rand(input int i);
    int op, f, imm, r, v;
    r   = int'($urandom_range(0, 99));
    op  = (r < 3) ? 7 : r % 7;
    f   = int'($urandom_range(0, 7));
    if (op == 5 && $urandom_range(0, 99) < 85) f = ($urandom_range(0, 1) == 1) ? 4 : 0;
    if (op == 6 && $urandom_range(0, 99) < 85) f = int'($urandom_range(0, 1));
    imm = int'($urandom_range(0, 255));
    if ($urandom_range(0, 99) < 90) begin
      case (op)
        1, 4: begin v = int'($urandom_range(0, 15)) - 8; imm = v & 255; end
        2, 3: begin v = int'($urandom_range(0, 127)) - 64; imm = v & 255; end
        5: imm = (f == 0) ? int'($urandom_range(0, 127)) : 16 * int'($urandom_range(0, 15));
        6: begin
          v   = int'($urandom_range(0, 127)) - 64;
          imm = (f == 1) ? (v & 255) : 16 * int'($urandom_range(0, 15));
        end
        default: ;
      endcase
    end
    set_t(i, op, f, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 7)), imm);
  endtask

  // Entered and left just after a rising edge.
  task automatic run_job(input int base, input int cnt, input int ntup, input int rdy_pct,
                         input int vld_pct, input bit spurious);
    int e_err, e_ea, e_acc, e_words, w, idx, cyc, nwr;
    exp_addr_q.delete();
    exp_data_q.delete();
    e_err = 0; e_ea = 0; e_acc = 0;
    for (int k = 0; k < ntup && k < cnt; k++) begin
      w = ref_enc(t_op[k], t_f[k], t_rd[k], t_rs1[k], t_rs2[k], t_imm[k]);
      e_acc++;
      if (w < 0) begin
        e_err = 1;
        e_ea  = (base + k) % 256;
        break;
      end
      exp_addr_q.push_back((base + k) % 256);
      exp_data_q.push_back(w);
    end
    e_words = exp_addr_q.size();

    start = 1'b1; base_addr = 8'(base); count = 9'(cnt);
    @(posedge clk); #1;
    start = 1'b0;
    if (cnt != 0) chk("busy_after_start", 32'(busy), 32'd1);

    idx = 0; cyc = 0; nwr = 0;
    while (!(done || (err && !mem_we)) && cyc < 2000) begin
      if (spurious && cyc == 0) begin
        start = 1'b1; base_addr = 8'(base + 128); count = 9'(cnt + 3);
      end else begin
        start = 1'b0;
      end
      in_valid = (idx < ntup) && ($urandom_range(0, 99) < vld_pct);
      if (idx < ntup) begin
        in_opcode = 3'(t_op[idx]); in_func = 3'(t_f[idx]); in_rd = 3'(t_rd[idx]);
        in_rs1 = 3'(t_rs1[idx]); in_rs2 = 3'(t_rs2[idx]); in_imm = 8'(t_imm[idx]);
      end
      mem_ready = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      if (mem_we && mem_ready) begin
        n_cmp++;
        assert (exp_addr_q.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_write observed=0x%0h expected=none", mem_addr);
        end
        if (exp_addr_q.size() != 0) begin
          chk("write_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
          chk("write_data", 32'(mem_wdata), 32'(exp_data_q.pop_front()));
          if (nwr < 16) g_wr_cyc[nwr] = cyc;
          nwr++;
        end
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
    g_cyc = cyc; g_nwr = nwr;
    chk("job_in_time", 32'(cyc < 2000), 32'd1);
    chk("done", 32'(done), 32'(e_err == 0));
    chk("err", 32'(err), 32'(e_err));
    chk("err_addr", 32'(err_addr), 32'(e_ea));
    chk("words_written", 32'(words_written), 32'(e_words));
    chk("tuples_accepted", 32'(idx), 32'(e_acc));
    chk("writes_missing", 32'(exp_addr_q.size()), 32'd0);
    chk("mem_we_idle", 32'(mem_we), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; in_valid = 1'b0;
    in_opcode = '0; in_func = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_words", 32'(words_written), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two legal tuples at full rate.
    set_t(0, 0, 2, 3, 5, 6, 0);
    set_t(1, 1, 0, 1, 2, 0, 8'hFD);
    run_job(8'h10, 2, 2, 100, 100, 1'b0);
    chk("t1_writes", 32'(g_nwr), 32'd2);
    chk("t1_back_to_back", 32'(g_wr_cyc[1] - g_wr_cyc[0]), 32'd1);

    // JALR held in the output stage while imem stalls for three cycles.
    start = 1'b1; base_addr = 8'h50; count = 9'd1;
    @(posedge clk); #1;
    start = 1'b0;
    in_opcode = 3'd5; in_func = 3'd4; in_rd = 3'd7; in_rs1 = 3'd4; in_rs2 = 3'd0; in_imm = 8'h30;
    in_valid = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    chk("stall_in_ready_first", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_mem_we", 32'(mem_we), 32'd1);
      chk("stall_addr", 32'(mem_addr), 32'h50);
      chk("stall_wdata", 32'(mem_wdata), 32'h39E5);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_we", 32'(mem_we), 32'd1);
    @(posedge clk); #1;
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_words", 32'(words_written), 32'd1);
    chk("stall_we_clear", 32'(mem_we), 32'd0);

    // Illegal I immediate in the middle of a job.
    set_t(0, 0, 1, 2, 3, 4, 0);
    set_t(1, 1, 0, 1, 2, 0, 8'h10);
    set_t(2, 0, 5, 6, 7, 1, 0);
    run_job(8'h60, 3, 3, 50, 100, 1'b0);

    // Address wrap.
    set_t(0, 0, 7, 1, 2, 3, 0);
    set_t(1, 5, 0, 4, 0, 0, 8'h55);
    run_job(8'hFF, 2, 2, 70, 100, 1'b0);

    // Empty job completes on the start edge itself.
    run_job(8'h33, 0, 0, 100, 100, 1'b0);
    chk("empty_job_cycles", 32'(g_cyc), 32'd0);
    chk("empty_job_writes", 32'(g_nwr), 32'd0);

    // start during RUN must not disturb the job in progress.
    set_t(0, 0, 1, 1, 1, 1, 0);
    set_t(1, 6, 1, 2, 0, 0, 8'hC3);
    run_job(8'h40, 2, 2, 100, 60, 1'b1);

    // Reset while a write is pending, then a clean job.
    set_t(0, 0, 3, 4, 5, 6, 0);
    start = 1'b1; base_addr = 8'h20; count = 9'd1;
    @(posedge clk); #1;
    start = 1'b0;
    in_opcode = 3'd0; in_func = 3'd3; in_rd = 3'd4; in_rs1 = 3'd5; in_rs2 = 3'd6; in_imm = 8'h00;
    in_valid = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_wdata", 32'(mem_wdata), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_err_addr", 32'(err_addr), 32'd0);
    chk("mid_rst_words", 32'(words_written), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1;
    set_t(0, 2, 0, 1, 2, 0, 8'h3F);
    set_t(1, 4, 6, 0, 3, 5, 8'hFA);
    set_t(2, 0, 0, 7, 7, 7, 0);
    run_job(8'h80, 3, 3, 80, 80, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 10; j++) begin
      int n;
      n = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) gen_rand(i);
      run_job(int'($urandom_range(0, 255)), n, n, 60, 70, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
- Inverse of the Octa16 instruction decoder: accepts decoded instruction fields over a valid/ready stream, packs them into 16-bit Octa16 instruction words, and writes them sequentially into instruction memory.
- Used by the boot/debug path to load programs into imem from a host or test sequencer.
- Checks each field tuple for encodability and stops on the first illegal tuple, reporting its address.

Parameters:
- ADDR_W, 8, imem word-address width. Address arithmetic wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; begins a load job. Sampled only in IDLE, DONE or ERR.
- base_addr  in  ADDR_W  first imem address, latched on start
- count  in  ADDR_W+1  number of words in the job, latched on start
- in_valid  in  1  field tuple valid
- in_ready  out  1  tuple accepted when in_valid && in_ready
- in_opcode  in  3  opcode
- in_func  in  3  func
- in_rd  in  3  rd field
- in_rs1  in  3  rs1 field
- in_rs2  in  3  rs2 field
- in_imm  in  8  immediate, in the decoder's 8-bit form
- mem_we  out  1  write request, held until mem_ready
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  16  encoded instruction word
- mem_ready  in  1  imem accepts the write this cycle when mem_we is high
- busy  out  1  high in RUN
- done  out  1  high in DONE
- err  out  1  high in ERR
- err_addr  out  ADDR_W  address the illegal tuple would have been written to
- words_written  out  ADDR_W+1  completed memory writes in the current job

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; all outputs 0; output stage empty.
- FSM states are IDLE, RUN, DONE, ERR.
- On start in IDLE, DONE or ERR:
  - latch base_addr and count; set next address = base_addr;
  - clear words_written, err and err_addr;
  - go to RUN, or to DONE if count==0.
- start while in RUN is ignored.
- Output stage is a one-entry register: mem_we = stage full.
- in_ready = (state==RUN) && (accepted < count) && (!mem_we || mem_ready).
- Latency: a tuple accepted at edge N drives mem_we/mem_addr/mem_wdata from cycle N+1.
  - Back-to-back throughput is 1 word/cycle while mem_ready=1.
  - Outputs stay stable while mem_we && !mem_ready.
- Each completed write (mem_we && mem_ready) increments words_written and the address. The address wraps from 2^ADDR_W-1 to 0.
- RUN -> DONE when words_written reaches count; this is the cycle after the last write completes.
- Encoding, word bits [2:0]=opcode in every case:
  - 000 R: [15]=0, [14:12]=rs2, [11:9]=rs1, [8:6]=rd, [5:3]=func. Always legal.
  - 001 I: [15:12]=imm[3:0], [11:9]=rs1, [8:6]=rd, [5:3]=func. Legal iff imm[7:3] all equal.
  - 010 L / 011 S: [15]=imm[7], [14:12]=imm[5:3], [11:9]=rs1, [8:6]=rd, [5:3]=imm[2:0]. Legal iff imm[7]==imm[6].
  - 100 B: [15]=imm[7], [14:12]=rs2, [11:9]=rs1, [8:6]=imm[2:0], [5:3]=func. Legal iff imm[7:3] all equal.
  - 101 with func=000 JAL: [15:9]=imm[6:0], [8:6]=rd, [5:3]=000. Legal iff imm[7]==0.
  - 101 with func=100 JALR: [15:12]=imm[7:4], [11:9]=rs1, [8:6]=rd, [5:3]=100. Legal iff imm[3:0]==0.
  - 101 with any other func: illegal.
  - 110 with func=001 ADDPC: [15:9]=imm[6:0], [8:6]=rd, [5:3]=001. Legal iff imm[7]==imm[6].
  - 110 with func=000 AUIR: [15:12]=imm[7:4], [11:9]=rs1, [8:6]=rd, [5:3]=000. Legal iff imm[3:0]==0.
  - 110 with any other func: illegal.
  - 111: illegal.
  - Fields not listed for a format are ignored.
- Illegal tuple:
  - The tuple is still consumed (handshake completes) but is not written.
  - err_addr = address it would have occupied, i.e. base + number of tuples accepted before it.
  - Go to ERR; in_ready drops the next cycle.
  - A word already held in the output stage still drains in ERR; words_written counts it.
- DONE and ERR hold until the next start. rst_n low in any state, including mid-write, aborts immediately to the reset values.

Test Plan:
- base=0x10, count=2; R{func=2, rd=3, rs1=5, rs2=6} then I{func=0, rd=1, rs1=2, imm=0xFD}, mem_ready=1 -> writes 0x6AD0@0x10 and 0xD441@0x11 on consecutive cycles; done=1; words_written=2.
- count=1; JALR{rd=7, rs1=4, imm=0x30}; mem_ready low for 3 cycles -> mem_we/addr/wdata=0x39E5 held stable for 3 cycles; in_ready=0 throughout; write completes on the 4th cycle.
- count=3; tuples R (legal), I imm=0x10 (illegal), R -> first word written; err=1; err_addr=base+1; third tuple never accepted; words_written=1.
- base=0xFF, count=2, ADDR_W=8 -> writes go to addresses 0xFF then 0x00.
- count=0 start -> DONE the next cycle with no mem_we; start pulsed during RUN -> ignored (latched base and count unchanged).
- rst_n=0 asserted while mem_we=1 -> at the next edge all outputs are 0 and state is IDLE; a subsequent start runs a clean job.
